// File: rtl/clk_div_checker.sv
// clk_div_checker: monitors the /2, /4, /8 clock divider outputs in the source clock domain.
// For each channel it measures the period in source-clock cycles. It checks that period
// against the expected ratio and reports per-channel lock and sticky error status.
//
// Ports
//   clk         source clock (also drives the divider)
//   rst         asynchronous active-low reset
//   clk2_in     divider /2 output
//   clk4_in     divider /4 output
//   clk8_in     divider /8 output
//   err_clr     synchronous pulse, clears the sticky error bits
//   sel         period_out source: 0=ch2, 1=ch4, 2=ch8, 3=zero
//   lock        per-channel lock  {ch8, ch4, ch2}
//   err         per-channel sticky error, same bit order as lock
//   period_out  last measured period of the selected channel
//   phase_err   sticky ch2/ch4/ch8 phase-alignment error
//
// Optional feature: define CLK_DIV_PHASE_CHECK_EN to build the phase checker.
// When it is not defined, phase_err is tied to 0.

// One measurement channel. EXP is the expected period in clk cycles.
module clk_div_ch #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int EXP        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic             rise_o,
  output logic             lock_o,
  output logic             err_o,
  output logic [WIDTH-1:0] meas_o
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} st_e;

  localparam logic [WIDTH:0] EXP_V = (WIDTH+1)'(EXP);
  localparam logic [WIDTH:0] TMO_V = (WIDTH+1)'(2*EXP);
  localparam logic [3:0]     LC_V  = 4'(LOCK_COUNT);

  logic             s_q, s_d, p_q, p_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, meas_q, meas_d;
  st_e              st_q, st_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             err_q, err_d;

  logic             rise, err_set;
  logic [WIDTH:0]   cnt_p1;   // one extra bit so saturation is visible
  logic [WIDTH-1:0] cnt_sat;

  always_comb begin
    s_d     = clk_in;
    p_d     = s_q;
    rise    = s_q & ~p_q;
    cnt_p1  = {1'b0, cnt_q} + 1'b1;
    cnt_sat = cnt_p1[WIDTH] ? '1 : cnt_p1[WIDTH-1:0];
    cnt_d   = cnt_sat;
    meas_d  = meas_q;
    st_d    = st_q;
    gcnt_d  = gcnt_q;
    err_set = 1'b0;
    if (rise) begin
      // cnt+1 at the rise is the rise-to-rise distance
      meas_d = cnt_sat;
      cnt_d  = '0;
      case (st_q)
        IDLE: begin
          // first edge only starts the measurement window
          st_d   = ACQ;
          gcnt_d = '0;
        end
        ACQ: begin
          if (cnt_p1 == EXP_V) begin
            gcnt_d = gcnt_q + 4'd1;
            if (gcnt_d == LC_V) st_d = LOCKED;
          end else begin
            err_set = 1'b1;
            gcnt_d  = '0;
          end
        end
        LOCKED: begin
          if (cnt_p1 != EXP_V) begin
            err_set = 1'b1;
            gcnt_d  = '0;
            st_d    = ACQ;
          end
        end
        default: st_d = IDLE;
      endcase
    end else if (st_q != IDLE && cnt_p1 == TMO_V) begin
      // stalled input: fires once, since cnt moves past the threshold
      err_set = 1'b1;
      gcnt_d  = '0;
      st_d    = IDLE;
    end
    // the error set wins over the clear
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= 1'b0;
      p_q    <= 1'b0;
      cnt_q  <= '0;
      meas_q <= '0;
      st_q   <= IDLE;
      gcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      meas_q <= meas_d;
      st_q   <= st_d;
      gcnt_q <= gcnt_d;
      err_q  <= err_d;
    end
  end

  assign rise_o = rise;
  assign lock_o = (st_q == LOCKED);
  assign err_o  = err_q;
  assign meas_o = meas_q;
endmodule

module clk_div_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk2_in,
  input  logic             clk4_in,
  input  logic             clk8_in,
  input  logic             err_clr,
  input  logic [1:0]       sel,
  output logic [2:0]       lock,
  output logic [2:0]       err,
  output logic [WIDTH-1:0] period_out,
  output logic             phase_err
);
  logic [2:0]            ch_in, rise;
  logic [2:0][WIDTH-1:0] meas;
  logic [WIDTH-1:0]      period_out_q, period_out_d;

  assign ch_in = {clk8_in, clk4_in, clk2_in};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    clk_div_ch #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .EXP(2 << i)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clk_in  (ch_in[i]),
      .err_clr (err_clr),
      .rise_o  (rise[i]),
      .lock_o  (lock[i]),
      .err_o   (err[i]),
      .meas_o  (meas[i])
    );
  end

  always_comb begin
    period_out_d = '0;
    case (sel)
      2'd0:    period_out_d = meas[0];
      2'd1:    period_out_d = meas[1];
      2'd2:    period_out_d = meas[2];
      default: period_out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) period_out_q <= '0;
    else      period_out_q <= period_out_d;
  end

  assign period_out = period_out_q;

`ifdef CLK_DIV_PHASE_CHECK_EN
  logic phase_err_q, phase_err_d, phase_set;

  // A slower channel must rise together with the next faster one, but only
  // once both channels are locked.
  always_comb begin
    phase_set   = (rise[1] & ~rise[0] & lock[1] & lock[0]) |
                  (rise[2] & ~rise[1] & lock[2] & lock[1]);
    phase_err_d = (phase_err_q & ~err_clr) | phase_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_err_q <= 1'b0;
    else      phase_err_q <= phase_err_d;
  end

  assign phase_err = phase_err_q;
`else
  wire unused_rise = ^rise;
  assign phase_err = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_checker.sv
module tb_clk_div_checker;
  localparam int WIDTH = 8;
  localparam int LC    = 4;

  logic             clk = 1'b0, rst = 1'b0;
  logic             clk2_in = 1'b0, clk4_in = 1'b0, clk8_in = 1'b0, err_clr = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic [2:0]       lock, err;
  logic [WIDTH-1:0] period_out;
  logic             phase_err;

  always #5 clk = ~clk;

  clk_div_checker #(.WIDTH(WIDTH), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst(rst), .clk2_in(clk2_in), .clk4_in(clk4_in), .clk8_in(clk8_in),
    .err_clr(err_clr), .sel(sel), .lock(lock), .err(err),
    .period_out(period_out), .phase_err(phase_err)
  );

  typedef struct packed {
    logic [2:0]       lock;
    logic [2:0]       err;
    logic [WIDTH-1:0] period;
    logic             phase;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   g[3];  // per-channel divider phase counters

  function automatic void check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference model. It works on edge timestamps: a rise seen at edge e measures
  // e minus the edge of the previous rise, or minus the reset edge for the first rise.
  int         m_edge, m_st[3], m_gc[3], m_ref[3], m_meas[3], m_x1[3], m_x2[3];
  logic [2:0] m_err;
  logic       m_ph;

  function automatic void model_reset();
    m_edge = 0; m_err = '0; m_ph = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_st[c] = 0; m_gc[c] = 0; m_ref[c] = 0; m_meas[c] = 0; m_x1[c] = 0; m_x2[c] = 0;
    end
  endfunction

  // Expected outputs after the next clock edge. Inputs x are sampled on that edge.
  function automatic exp_t model_step(input logic [2:0] x, input logic clr, input logic [1:0] s);
    exp_t       r;
    int         mo[3];
    logic [2:0] rs, lk, set;
    int         age, expv;
    m_edge++;
    for (int c = 0; c < 3; c++) begin
      expv   = 2 << c;
      mo[c]  = m_meas[c];
      lk[c]  = (m_st[c] == 2);
      rs[c]  = (m_x1[c] == 1) && (m_x2[c] == 0);
      set[c] = 1'b0;
      age    = m_edge - m_ref[c];
      if (rs[c]) begin
        m_meas[c] = (age > 255) ? 255 : age;
        m_ref[c]  = m_edge;
        if (m_st[c] == 0) begin
          m_st[c] = 1; m_gc[c] = 0;
        end else if (age == expv) begin
          if (m_st[c] == 1) begin
            m_gc[c]++;
            if (m_gc[c] == LC) m_st[c] = 2;
          end
        end else begin
          set[c] = 1'b1; m_gc[c] = 0; m_st[c] = 1;
        end
      end else if (m_st[c] != 0 && age == 2 * expv) begin
        set[c] = 1'b1; m_gc[c] = 0; m_st[c] = 0;
      end
      m_x2[c] = m_x1[c];
      m_x1[c] = int'(x[c]);
    end
    m_err = (clr ? 3'b000 : m_err) | set;
`ifdef CLK_DIV_PHASE_CHECK_EN
    m_ph = (clr ? 1'b0 : m_ph) |
           ((rs[1] && !rs[0] && lk[1] && lk[0]) || (rs[2] && !rs[1] && lk[2] && lk[1]));
`endif
    for (int c = 0; c < 3; c++) r.lock[c] = (m_st[c] == 2);
    r.err    = m_err;
    r.period = (s == 2'd3) ? '0 : WIDTH'(mo[s]);
    r.phase  = m_ph;
    return r;
  endfunction

  // One clock of stimulus. hold forces a channel low; pause freezes its divider for a cycle.
  task automatic drive_cycle(input logic [2:0] hold, input logic [2:0] pause,
                             input logic clr, input logic [1:0] s);
    logic [2:0] x;
    for (int c = 0; c < 3; c++) x[c] = (((g[c] >> c) & 1) == 1) && !hold[c];
    clk2_in = x[0]; clk4_in = x[1]; clk8_in = x[2];
    err_clr = clr; sel = s;
    sb.push_back(model_step(x, clr, s));
    for (int c = 0; c < 3; c++) if (!pause[c]) g[c]++;
    @(negedge clk);
  endtask

  task automatic run_ideal(input int n);
    for (int i = 0; i < n; i++) drive_cycle(3'b000, 3'b000, 1'b0, 2'($urandom_range(3)));
  endtask

  // Pulse reset between edges; the outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_period", period_out, 0);
    check("rst_phase", phase_err, 0);
    #1 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) g[c] = 0;
  endtask

  // Monitor: every DUT edge is compared against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("lock", lock, e.lock);
        check("err", err, e.err);
        check("period_out", period_out, e.period);
        check("phase_err", phase_err, e.phase);
      end
    end
  end

  initial begin : stim
    int         hc[3];
    logic [2:0] hd, ps;
    logic       clr, seen9;
    int         hits;
    logic [7:0] exp_per [4];
    exp_per[0] = 8'd2; exp_per[1] = 8'd4; exp_per[2] = 8'd8; exp_per[3] = 8'd0;
    model_reset();
    for (int c = 0; c < 3; c++) begin g[c] = 0; hc[c] = 0; end
    repeat (3) @(negedge clk);
    check("init_lock", lock, 0);
    check("init_err", err, 0);
    check("init_period", period_out, 0);
    check("init_phase", phase_err, 0);
    rst = 1'b1;

    // Ideal divider from a common reset.
    run_ideal(80);
    check("ideal_lock", lock, 3'b111);
    check("ideal_err", err, 0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(3'b000, 3'b000, 1'b0, 2'(k));
      drive_cycle(3'b000, 3'b000, 1'b0, 2'(k));
      check("ideal_period", period_out, exp_per[k]);
    end

    // clk4 stalls low, then resumes.
    for (int i = 0; i < 30; i++) drive_cycle(3'b010, 3'b000, 1'b0, 2'd1);
    check("stall_err", err, 3'b010);
    check("stall_lock", lock, 3'b101);
    run_ideal(60);
    check("resume_lock", lock, 3'b111);
    drive_cycle(3'b000, 3'b000, 1'b1, 2'd0);
    check("clr_err", err, 0);

    // One clk8 period stretched to 9.
    seen9 = 1'b0;
    drive_cycle(3'b000, 3'b100, 1'b0, 2'd2);
    for (int i = 0; i < 14; i++) begin
      drive_cycle(3'b000, 3'b000, 1'b0, 2'd2);
      if (period_out == 8'd9) seen9 = 1'b1;
    end
    check("stretch_seen9", seen9, 1);
    check("stretch_err", err, 3'b100);
    check("stretch_lock", lock, 3'b011);
    run_ideal(40);
    check("stretch_relock", lock, 3'b111);
    drive_cycle(3'b000, 3'b000, 1'b1, 2'd0);
    check("stretch_clr", err, 0);

    // err_clr on the same edge as a ch2 mismatch: the set must win.
    hits = 0;
    drive_cycle(3'b000, 3'b001, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      clr = (m_x1[0] == 1) && (m_x2[0] == 0) && ((m_edge + 1 - m_ref[0]) != 2);
      if (clr) hits++;
      drive_cycle(3'b000, 3'b000, clr, 2'd0);
    end
    check("coincide_hits", hits, 1);
    check("coincide_err", err, 3'b001);

    // Random jitter, stalls, clears and one async reset in the middle.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 3; c++) begin
        ps[c] = ($urandom_range(15) == 0);
        if (hc[c] > 0) hc[c]--;
        else if ($urandom_range(63) == 0) hc[c] = $urandom_range(20, 1);
        hd[c] = (hc[c] > 0);
      end
      if (i == 200) do_reset();
      drive_cycle(hd, ps, $urandom_range(7) == 0, 2'($urandom_range(3)));
    end

    // Clean reacquisition after a reset.
    do_reset();
    run_ideal(80);
    check("reacq_lock", lock, 3'b111);
    check("reacq_err", err, 0);

    @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
